// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: one-cold FSM encodings and frame defaults shared by the UART transmitter and receiver.
package uart_tx_pkg;
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b1110,
        ST_START = 4'b1101,
        ST_DATA  = 4'b1011,
        ST_STOP  = 4'b0111
    } state_e;
    localparam int TICK16_DEF     = 16;
    localparam int SIZE_TRAMA_DEF = 8;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start bit + LSB-first data + stop bit, 16x oversampled tick timing, registered outputs.
module uart_tx #(
    parameter int SIZE_TRAMA_BIT = uart_tx_pkg::SIZE_TRAMA_DEF,
    parameter int TICK16         = uart_tx_pkg::TICK16_DEF,
    parameter int STOP_TICKS     = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_tx_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_tx_done,
    output logic       o_busy
);
    import uart_tx_pkg::*;
    state_e                    state_q;
    logic                      tx_q;
    logic                      done_q;
    logic                      busy_q;
    logic [4:0]                tick_cnt_q;
    logic [2:0]                bit_cnt_q;
    logic [SIZE_TRAMA_BIT-1:0] shift_q;
    logic                      tick_last;
    logic                      stop_last;
    logic                      bit_last;
    assign tick_last = tick_cnt_q == 5'(TICK16 - 1);
    assign stop_last = tick_cnt_q == 5'(STOP_TICKS - 1);
    assign bit_last  = bit_cnt_q == 3'(SIZE_TRAMA_BIT - 1);
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_tx_start) begin
                        shift_q    <= i_data[SIZE_TRAMA_BIT-1:0];
                        tick_cnt_q <= '0;
                        state_q    <= ST_START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (i_tick && tick_last) begin
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= ST_DATA;
                        tx_q       <= shift_q[0];
                    end else if (i_tick) begin
                        tick_cnt_q <= tick_cnt_q + 5'd1;
                    end
                end
                ST_DATA: begin
                    // tx_q is loaded with the next line level so the pin changes on the boundary edge itself
                    if (i_tick && tick_last) begin
                        tick_cnt_q <= '0;
                        shift_q    <= shift_q >> 1;
                        state_q    <= bit_last ? ST_STOP : ST_DATA;
                        tx_q       <= bit_last ? 1'b1 : shift_q[1];
                        bit_cnt_q  <= bit_last ? bit_cnt_q : bit_cnt_q + 3'd1;
                    end else if (i_tick) begin
                        tick_cnt_q <= tick_cnt_q + 5'd1;
                    end
                end
                ST_STOP: begin
                    if (i_tick && stop_last) begin
                        tick_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (i_tick) begin
                        tick_cnt_q <= tick_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    tick_cnt_q <= '0;
                end
            endcase
        end
    end
    assign o_tx      = tx_q;
    assign o_tx_done = done_q;
    assign o_busy    = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame checks plus a line-decoding scoreboard for the UART transmitter.
module tb_uart_tx;
    typedef struct {
        logic [7:0] data;
        bit         aborted;
    } exp_t;
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    logic       clk;
    logic       i_reset;
    logic       tick;
    logic       tick_en;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done;
    logic       o_busy;
    int         cyc;
    int         checks;
    int         errors;
    int         done_cnt;
    bit         mon_busy;
    exp_t       q[$];
    uart_tx dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_tick     (tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done),
        .o_busy     (o_busy)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        tick = 1'b0;
        cyc  = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tick = tick_en && (cyc % 4 == 0);
        end
    end
    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (o_tx_done === 1'b1) done_cnt++;
        end
    end
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask
    initial begin
        logic       prev;
        logic       st;
        logic       sp;
        logic [7:0] b;
        exp_t       e;
        prev     = 1'b1;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (i_reset === 1'b0 && prev === 1'b1 && o_tx === 1'b0) begin
                mon_busy = 1'b1;
                repeat (32) @(negedge clk);
                st = o_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (64) @(negedge clk);
                    b[i] = o_tx;
                end
                repeat (64) @(negedge clk);
                sp = o_tx;
                if (q.size() == 0) begin
                    chk("sb_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    if (!e.aborted) begin
                        chk("sb_start_bit", {31'd0, st}, 32'd0);
                        chk("sb_byte", {24'd0, b}, {24'd0, e.data});
                        chk("sb_stop_bit", {31'd0, sp}, 32'd1);
                    end
                end
                mon_busy = 1'b0;
            end
            prev = o_tx;
        end
    end
    task automatic launch(input logic [7:0] d, input bit ab);
        int g;
        g = 0;
        do begin
            @(posedge clk);
            #2;
            g++;
        end while (tick !== 1'b1 && g < 8);
        i_tx_start = 1'b1;
        i_data     = d;
        q.push_back('{data: d, aborted: ab});
        @(posedge clk);
        #2;
        i_tx_start = 1'b0;
        i_data     = ~d;
    endtask
    task automatic wait_done(input string nm);
        int g;
        g = 0;
        do begin
            @(posedge clk);
            #2;
            g++;
        end while (o_tx_done !== 1'b1 && g < 2000);
        chk({nm, "_done_seen"}, {31'd0, o_tx_done}, 32'd1);
    endtask
    task automatic send_check(input logic [7:0] d, input logic [9:0] fr, input string nm);
        int bad_tx;
        int bad_busy;
        int d0;
        bad_tx   = 0;
        bad_busy = 0;
        d0       = done_cnt;
        launch(d, 1'b0);
        for (int c = 0; c < 640; c++) begin
            @(negedge clk);
            if (o_tx !== fr[c/64]) bad_tx++;
            if (o_busy !== 1'b1 || o_tx_done !== 1'b0) bad_busy++;
        end
        chk({nm, "_wave_bad_cycles"}, bad_tx, 0);
        chk({nm, "_busy_bad_cycles"}, bad_busy, 0);
        @(negedge clk);
        chk({nm, "_done_at_640"}, {31'd0, o_tx_done}, 32'd1);
        chk({nm, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    endtask
    initial begin
        vec_t tbl[5];
        int   bad_tx;
        int   bad_busy;
        int   bad_done;
        int   d0;
        int   g;
        logic v;
        tbl[0] = '{8'hA5, 10'b1101001010};
        tbl[1] = '{8'h00, 10'b1000000000};
        tbl[2] = '{8'hFF, 10'b1111111110};
        tbl[3] = '{8'h55, 10'b1010101010};
        tbl[4] = '{8'h3C, 10'b1001111000};
        checks     = 0;
        errors     = 0;
        i_reset    = 1'b1;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        tick_en    = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_tx", {31'd0, o_tx}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_tx_done}, 32'd0);
        i_reset  = 1'b0;
        bad_tx   = 0;
        bad_busy = 0;
        bad_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_tx !== 1'b1) bad_tx++;
            if (o_busy !== 1'b0) bad_busy++;
            if (o_tx_done !== 1'b0) bad_done++;
        end
        chk("idle_tx", bad_tx, 0);
        chk("idle_busy", bad_busy, 0);
        chk("idle_done", bad_done, 0);
        for (int i = 0; i < 5; i++) send_check(tbl[i].data, tbl[i].frame, $sformatf("vec%0d", i));
        launch(8'h7E, 1'b0);
        wait_done("b2b_first");
        chk("b2b_line_high_in_done", {31'd0, o_tx}, 32'd1);
        i_tx_start = 1'b1;
        i_data     = 8'h81;
        q.push_back('{data: 8'h81, aborted: 1'b0});
        @(posedge clk);
        #2;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        chk("b2b_no_gap", {31'd0, o_tx}, 32'd0);
        chk("b2b_busy", {31'd0, o_busy}, 32'd1);
        wait_done("b2b_second");
        repeat (20) @(negedge clk);
        d0 = done_cnt;
        launch(8'hF0, 1'b0);
        repeat (276) @(negedge clk);
        @(posedge clk);
        #2;
        i_tx_start = 1'b1;
        i_data     = 8'h12;
        @(posedge clk);
        #2;
        i_tx_start = 1'b0;
        wait_done("busy_start");
        repeat (100) @(negedge clk);
        chk("busy_start_one_done", done_cnt - d0, 1);
        chk("busy_start_line_idle", {31'd0, o_tx}, 32'd1);
        chk("busy_start_not_busy", {31'd0, o_busy}, 32'd0);
        d0 = done_cnt;
        launch(8'h3C, 1'b1);
        repeat (394) @(negedge clk);
        tick_en = 1'b0;
        v       = o_tx;
        bad_tx  = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_tx !== v || o_busy !== 1'b1) bad_tx++;
        end
        chk("no_tick_hold", bad_tx, 0);
        @(posedge clk);
        #2;
        i_reset = 1'b1;
        @(posedge clk);
        #2;
        chk("abort_tx_high", {31'd0, o_tx}, 32'd1);
        chk("abort_not_busy", {31'd0, o_busy}, 32'd0);
        i_reset = 1'b0;
        tick_en = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        g = 0;
        while (mon_busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        send_check(8'h99, 10'b1100110010, "after_abort");
        g = 0;
        while ((q.size() != 0 || mon_busy) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
